// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and issues one instruction-memory request
// at a time. It holds the returned word in an output register and presents it to
// decode. Execute-side redirects reload the PC and squash any fetch still in flight.
//
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1.
// Once valid is raised, the payload is held stable until that transfer. The only
// exception is a redirect, which retracts a pending request or held instruction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  inst_op,
  output logic [5:0]  inst_funct,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_count
);

  // S_REQ : request outstanding on the memory port
  // S_WAIT: request accepted, waiting for the response word
  // S_FULL: output register holds an instruction for decode
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  // Set when the response of an accepted request must be thrown away
  logic        drop;
  logic        drop_n;
  logic        load_inst;
  logic        count_inc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] count_q;
  logic [31:0] redirect_pc;

  // Redirect targets are word aligned; the low two bits are masked off
  assign redirect_pc = redirect_target & 32'hFFFF_FFFC;

  // Next-state, next-PC and drop flag; a redirect overrides every other event
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    drop_n    = drop;
    load_inst = 1'b0;
    count_inc = 1'b0;
    if (redirect_valid) begin
      pc_n = redirect_pc;
      case (state)
        S_REQ: begin
          // An accepted request still returns a word, which must be dropped.
          // An unaccepted one is simply retracted.
          if (imem_req_ready) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            // The returning word is the stale one; nothing left in flight
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        S_FULL: begin
          // A word taken by decode in this same cycle still counts
          state_n   = S_REQ;
          count_inc = inst_ready;
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = S_REQ;
            end else begin
              load_inst = 1'b1;
              pc_n      = pc + 32'd4;
              state_n   = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (inst_ready) begin
            count_inc = 1'b1;
            state_n   = S_REQ;
          end
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

  // Control state register: FSM state, PC and drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
    end
  end

  // Output register: captures the fetched word and the PC it came from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else if (load_inst) begin
      inst_q    <= imem_rsp_data;
      inst_pc_q <= pc;
    end
  end

  // Count of instructions handed to decode, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else if (count_inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_addr      = pc;
  assign inst_valid     = (state == S_FULL);
  assign inst           = inst_q;
  assign inst_op        = inst_q[31:26];
  assign inst_funct     = inst_q[5:0];
  assign inst_pc        = inst_pc_q;
  assign inst_pc_plus4  = inst_pc_q + 32'd4;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It provides a behavioural instruction memory with one
// outstanding request and random latency. A reference model tracks the next
// program-order address and the expected decode count. Every decode-side word
// must come from that address, and redirects restart it.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [5:0]  inst_op;
  logic [5:0]  inst_funct;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetch_count;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_op         (inst_op),
    .inst_funct      (inst_funct),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count)
  );

  // Clock
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  bit          prev_hold;
  bit          prev_redir;
  logic [31:0] prev_inst;
  logic [31:0] prev_inst_pc;

  // Memory model state
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_data;
  int          lat_min;
  int          lat_max;

  // Stimulus knobs (percent probabilities)
  int          p_req_ready;
  int          p_inst_ready;
  int          p_redir;
  bit          pend_redir;
  logic [31:0] pend_tgt;
  logic [31:0] saved_count;

  // Memory contents: a couple of fixed words, the rest a hash of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0000_0008;
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model over the coming edge
  task automatic model_step();
    logic [31:0] w;
    if (prev_redir) chk("valid_after_redirect", 32'(inst_valid), 32'd0);
    if (prev_hold) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_inst_pc", inst_pc, prev_inst_pc);
    end
    chk("fetch_count", fetch_count, exp_count);
    if (imem_req_valid) begin
      chk("req_addr", imem_addr, exp_pc);
      chk("req_while_full", 32'(inst_valid), 32'd0);
    end
    if (inst_valid) begin
      w = mem_word(exp_pc);
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, w);
      chk("inst_op", 32'(inst_op), 32'(w[31:26]));
      chk("inst_funct", 32'(inst_funct), 32'(w[5:0]));
      chk("inst_pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
    end
    prev_hold    = inst_valid && !inst_ready && !redirect_valid;
    prev_redir   = redirect_valid;
    prev_inst    = inst;
    prev_inst_pc = inst_pc;
    if (inst_valid && inst_ready) begin
      exp_count = exp_count + 32'd1;
      exp_pc    = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = redirect_target & 32'hFFFF_FFFC;
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_wait = int'($urandom_range(lat_max - 1, lat_min - 1));
      mem_data = mem_word(imem_addr);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then check and update the model
  task automatic tick();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data;
        mem_busy       = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    imem_req_ready = (int'($urandom_range(99, 0)) < p_req_ready);
    inst_ready     = (int'($urandom_range(99, 0)) < p_inst_ready);
    if (pend_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = pend_tgt;
      pend_redir      = 1'b0;
    end else if (int'($urandom_range(99, 0)) < p_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = $urandom;
    end else begin
      redirect_valid  = 1'b0;
      redirect_target = $urandom;
    end
    model_step();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inst_valid) break;
    end
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req_valid) break;
    end
    chk(tag, 32'(imem_req_valid), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    pend_redir = 1'b1;
    pend_tgt   = tgt;
    tick();
  endtask

  task automatic model_reset();
    exp_pc     = 32'h0000_0100;
    exp_count  = 32'd0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    mem_busy   = 1'b0;
    mem_wait   = 0;
  endtask

  initial begin
    // Reset phase
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'd0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    pend_redir      = 1'b0;
    pend_tgt        = 32'd0;
    mem_data        = 32'd0;
    prev_inst       = 32'd0;
    prev_inst_pc    = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0100);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_op", 32'(inst_op), 32'd0);
    chk("rst_inst_funct", 32'(inst_funct), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc_plus4", inst_pc_plus4, 32'd4);
    chk("rst_fetch_count", fetch_count, 32'd0);
    rst = 1'b0;

    // Straight-line fetch with a 1-cycle memory: one instruction every 3 cycles
    p_req_ready = 100; p_inst_ready = 100; p_redir = 0;
    lat_min = 1; lat_max = 1;
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, 32'h0000_0100);
    repeat (8) tick();
    tick();
    chk("count_after_three", fetch_count, 32'd3);

    // jr word held for 5 cycles with decode stalled
    p_inst_ready = 0;
    redirect_to(32'h0000_0040);
    wait_valid("jr_valid_seen");
    chk("jr_inst_pc", inst_pc, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("jr_op_held", 32'(inst_op), 32'd0);
      chk("jr_funct_held", 32'(inst_funct), 32'h0000_0008);
      chk("jr_no_request", 32'(imem_req_valid), 32'd0);
    end
    p_inst_ready = 100;
    tick();

    // Redirect while the request to 0x200 is in flight: DEADBEEF is dropped
    lat_min = 3; lat_max = 3;
    redirect_to(32'h0000_0200);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req_valid && imem_addr == 32'h0000_0200) break;
    end
    chk("req_200_seen", imem_addr, 32'h0000_0200);
    redirect_to(32'h0000_0400);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("no_valid_from_stale", 32'(inst_valid), 32'd0);
      if (imem_req_valid) break;
    end
    chk("req_after_drop", imem_addr, 32'h0000_0400);
    lat_min = 1; lat_max = 1;

    // Redirect while holding an instruction, decode not ready
    p_inst_ready = 0;
    redirect_to(32'h0000_0010);
    wait_valid("full_valid_seen");
    chk("full_inst_pc", inst_pc, 32'h0000_0010);
    saved_count = fetch_count;
    redirect_to(32'h0000_0300);
    tick();
    chk("full_squashed", 32'(inst_valid), 32'd0);
    chk("full_count_kept", fetch_count, saved_count);
    chk("full_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("full_next_req_addr", imem_addr, 32'h0000_0300);
    p_inst_ready = 100;

    // Misaligned redirect target
    redirect_to(32'h0000_0503);
    wait_req("align_req_seen");
    chk("align_req_addr", imem_addr, 32'h0000_0500);

    // PC wraps at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    wait_valid("wrap_valid_seen");
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", inst_pc_plus4, 32'd0);
    wait_req("wrap_req_seen");
    chk("wrap_req_addr", imem_addr, 32'd0);

    // Reset while waiting on a response that is marked for dropping
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req_valid && imem_req_ready) break;
    end
    redirect_to(32'h0000_0600);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_fetch_count", fetch_count, 32'd0);
    chk("mid_rst_imem_addr", imem_addr, 32'h0000_0100);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_addr, 32'h0000_0100);
    wait_valid("post_rst_valid_seen");
    chk("post_rst_inst_pc", inst_pc, 32'h0000_0100);

    // Randomized traffic against the model
    p_req_ready = 70; p_inst_ready = 60; p_redir = 8;
    lat_min = 1; lat_max = 3;
    repeat (1500) tick();
    p_redir = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue MIPS core. It sits directly upstream of the control unit and owns the PC. It issues one request at a time to instruction memory and holds the returned word in an output register. It hands that word, with its Op/Funct fields split out, to decode over a valid/ready handshake. It also accepts PC redirects for branch, j, jal and jr from the execute side and discards stale fetches.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request; forced 0 while rst is high.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  byte address of the request; equals pc.
- imem_rsp_valid  in  1  response word valid; at most one per accepted request.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  output register holds a live instruction.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  held instruction word.
- inst_op  out  6  inst[31:26], to control unit Op.
- inst_funct  out  6  inst[5:0], to control unit Funct.
- inst_pc  out  32  address the held instruction was fetched from.
- inst_pc_plus4  out  32  inst_pc + 4, used as the link value for jal.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_target  in  32  new PC; bits [1:0] are ignored and taken as 0.
- fetch_count  out  32  number of instructions accepted by decode.

## Operation

- Registers:
  - pc[31:0]
  - state ∈ {S_REQ, S_WAIT, S_FULL}
  - drop flag
  - output register (inst, inst_pc)
  - fetch_count
- S_REQ: imem_req_valid=1 and imem_addr=pc. When imem_req_ready=1, go to S_WAIT.
- S_WAIT: no request. When imem_rsp_valid=1:
  - If drop=1: clear drop, go to S_REQ; the response is discarded.
  - Else: inst←imem_rsp_data, inst_pc←pc, pc←pc+4, go to S_FULL.
- S_FULL: inst_valid=1. When inst_ready=1: fetch_count←fetch_count+1, go to S_REQ.
- inst_valid is 1 exactly when state==S_FULL.
- PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0. fetch_count also wraps at 2^32.
- redirect_valid=1 has priority over all other events. It sets pc←{redirect_target[31:2],2'b00}. Next state:
  - S_REQ with imem_req_ready=1: S_WAIT, drop←1.
  - S_REQ with imem_req_ready=0: S_REQ. The unaccepted request is retracted, and imem_addr changes to the target on the next cycle.
  - S_WAIT with imem_rsp_valid=0: S_WAIT, drop←1.
  - S_WAIT with imem_rsp_valid=1: S_REQ. The response is discarded, and drop stays 0.
  - S_FULL: S_REQ; the held instruction is discarded.
  - If inst_ready=1 in the same S_FULL cycle, the transfer still counts: fetch_count increments, and decode has already taken the word.
- Redirect while drop=1 already set (S_WAIT, no response): drop stays 1, and pc takes the newest target.
- Reset (asynchronous, any state, mid-transaction included):
  - pc=RESET_PC, state=S_REQ, drop=0.
  - inst=0, inst_pc=0, fetch_count=0.
  - All outputs: inst_valid=0, imem_req_valid=0 (while rst=1), imem_addr=RESET_PC, inst_op=0, inst_funct=0, inst_pc_plus4=4.
- A response still in flight when reset is applied is the memory's responsibility; the memory is reset by the same rst.

## Timing

- First request: imem_req_valid=1 in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Request accepted in cycle N (valid&ready): response is possible from N+1 at the earliest. inst_valid=1 from the cycle after imem_rsp_valid.
- Decode handshake in cycle M (inst_valid&inst_ready): the next request is issued in M+1.
- Peak throughput with a 1-cycle memory and inst_ready held at 1: one instruction per 3 cycles.
- inst, inst_pc, inst_op, inst_funct and inst_pc_plus4 are stable while inst_valid=1 and inst_ready=0.
- imem_addr is stable while imem_req_valid=1 and imem_req_ready=0, except in a redirect cycle.
- Redirect in cycle R: the new address appears on imem_addr no later than R+1 (or after the dropped response returns). No instruction fetched before R reaches decode after R.

## Test plan

- Reset, RESET_PC=32'h100, memory with 1-cycle latency, inst_ready=1. Required:
  - imem_addr sequence 100, 104, 108.
  - inst_pc matches each address.
  - inst_pc_plus4 = inst_pc + 4.
  - fetch_count=3 after the third handshake.
- Word 32'h0000_0008 (jr) returned. Required: inst_op=6'b000000 and inst_funct=6'b001000, both held while inst_ready=0 for 5 cycles; no new request is issued during those cycles.
- Request at pc=32'h200 accepted, then redirect_valid with target 32'h400 before the response arrives. Required:
  - The response word 32'hDEAD_BEEF never makes inst_valid rise.
  - The next imem_addr is 32'h400.
- Redirect to 32'h300 while in S_FULL holding pc 32'h10, with inst_ready=0. Required: inst_valid=0 in the next cycle, next request at 32'h300, fetch_count unchanged.
- Redirect target 32'h0000_0503. Required: fetch address is 32'h0000_0500. Separately, pc=32'hFFFF_FFFC fetched: next imem_addr is 32'h0.
- rst asserted while in S_WAIT with drop=1. Required: in the same cycle inst_valid=0, imem_req_valid=0 and fetch_count=0. After release: first request at RESET_PC with drop=0.
